// File: rtl/avalon_dram_responder_if.sv
// Avalon-MM command/response bundle between the accelerator
// master and the DRAM window responder.
interface avalon_dram_responder_if #(
  parameter int DATA_W = 256
);
  logic [31:0]       avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic              avs_readdatavalid;
  logic [DATA_W-1:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_waitrequest,
    input  avs_readdatavalid,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_waitrequest,
    output avs_readdatavalid,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_dram_responder.sv
// Avalon-MM responder for the 256-bit DRAM window: wait-state
// stall, pipelined reads and a backdoor preload port.
module avalon_dram_responder #(
  parameter int DATA_W       = 256,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 3,
  parameter int WAIT_CYCLES  = 1,
  parameter int MAX_PENDING  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_dram_responder_if.slave   avs,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_index,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     err_flag,
  output logic [15:0]              wr_count,
  output logic [15:0]              rd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LAST = READ_LATENCY - 1;

  typedef logic [DATA_W-1:0] word_t;

  word_t             mem_q [DEPTH];
  word_t             mem_d [DEPTH];
  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pv_d;
  word_t             pd_q [READ_LATENCY];
  word_t             pd_d [READ_LATENCY];
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        pending_q, pending_d;
  logic              err_q, err_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;

  logic          req;
  logic          is_wr;
  logic          is_rd;
  logic          addr_err;
  logic          accept;
  logic          rdv;
  logic [3:0]    pend_eff;
  logic [AW-1:0] idx;

  assign req      = avs.avs_read | avs.avs_write;
  assign is_wr    = avs.avs_write;
  assign is_rd    = avs.avs_read & ~avs.avs_write;
  assign idx      = avs.avs_address[5 +: AW];
  assign addr_err = (avs.avs_address[4:0] != 5'd0) ||
                    (avs.avs_address >= 32'(DEPTH * 32));
  assign rdv      = pv_q[LAST];

  // A returning read frees its slot in the same cycle.
  assign pend_eff = pending_q - 4'(rdv);
  assign accept   = req &&
                    (wait_cnt_q == 3'(WAIT_CYCLES)) &&
                    (is_wr || pend_eff < 4'(MAX_PENDING));

  assign avs.avs_waitrequest   = ~accept;
  assign avs.avs_readdatavalid = rdv;
  assign avs.avs_readdata      = pd_q[LAST];

  assign err_flag = err_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req || accept) begin
      wait_cnt_d = 3'd0;
    end else if (wait_cnt_q != 3'(WAIT_CYCLES)) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d[load_index] = load_data;
    end
    if (accept && is_wr && !addr_err) begin
      mem_d[idx] = avs.avs_writedata;
    end
  end

  // Data registers load only behind a valid bit, so the
  // output stage holds the last returned word.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = accept && is_rd;
    pd_d[0] = pd_q[0];
    if (pv_d[0]) begin
      pd_d[0] = addr_err ? '0 : mem_q[idx];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
    end
  end

  always_comb begin
    pending_d = pending_q + 4'(accept && is_rd) - 4'(rdv);
    err_d     = err_q |
                (accept && (addr_err ||
                 (avs.avs_read && avs.avs_write)));
    wr_cnt_d  = wr_cnt_q + 16'(accept && is_wr);
    rd_cnt_d  = rd_cnt_q + 16'(accept && is_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
      pv_q       <= '0;
      wait_cnt_q <= 3'd0;
      pending_q  <= 4'd0;
      err_q      <= 1'b0;
      wr_cnt_q   <= 16'd0;
      rd_cnt_q   <= 16'd0;
    end else begin
      mem_q      <= mem_d;
      pd_q       <= pd_d;
      pv_q       <= pv_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end
endmodule

// File: tb/tb_avalon_dram_responder.sv
// Bench for avalon_dram_responder: vector table, read scoreboard
// and hand sequences for pipelining, collision and reset.
module tb_avalon_dram_responder;
  typedef logic [255:0] word_t;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    word_t       d;
    logic        err;
  } vec_t;

  typedef struct {
    word_t data;
    int    due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_dram_responder_if m ();
  avalon_dram_responder_if m0 ();

  logic        load_en;
  logic [3:0]  load_index;
  word_t       load_data;
  logic        err_flag, err0;
  logic [15:0] wr_count, rd_count, wr0, rd0;

  avalon_dram_responder dut (
    .clk(clk), .reset(reset), .avs(m),
    .load_en(load_en), .load_index(load_index),
    .load_data(load_data), .err_flag(err_flag),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  avalon_dram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .avs(m0),
    .load_en(load_en), .load_index(load_index),
    .load_data(load_data), .err_flag(err0),
    .wr_count(wr0), .rd_count(rd0)
  );

  int          total = 0;
  int          bad = 0;
  word_t       ref_mem [16];
  logic [15:0] wr_m, rd_m;
  logic        err_m;
  exp_t        exp_q [$];
  exp_t        mon_e;

  function automatic void chk(string name, word_t act, word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && m.avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdv_spurious: got pulse at cycle %0d want none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", m.avs_readdata, mon_e.data);
        chk("rd_cycle", word_t'(cyc), word_t'(mon_e.due));
      end
    end
  end

  task automatic cmd(input logic w, input logic r,
                     input logic [31:0] a, input word_t d,
                     output int waited);
    logic e;
    exp_t x;
    m.avs_write = w;
    m.avs_read = r;
    m.avs_address = a;
    m.avs_writedata = d;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!m.avs_waitrequest) break;
      waited++;
      if (waited > 40) break;
    end
    if (waited > 40) begin
      total++;
      bad++;
      $display("FAIL cmd_timeout: addr %h never accepted", a);
    end else begin
      e = (a[4:0] != 5'd0) || (a >= 32'd512);
      err_m = err_m | e | (w & r);
      if (w) begin
        wr_m++;
        if (!e) ref_mem[a[8:5]] = d;
      end else if (r) begin
        rd_m++;
        x.data = e ? '0 : ref_mem[a[8:5]];
        x.due = cyc + 3;
        exp_q.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    m.avs_write = 1'b0;
    m.avs_read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d reads left want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  vec_t  tbl [10];
  int    waited;
  int    acc_c [$];
  int    val_c [$];
  word_t val_d [$];
  int    nacc;
  int    exp_acc [3];
  int    exp_val [3];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'd64,  {32{8'hA5}}, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'd64,  '0,          1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'd480, '0,          1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'd32,  {32{8'h77}}, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'd32,  '0,          1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'd512, '0,          1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'd33,  {32{8'hFF}}, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'd32,  '0,          1'b1};
    tbl[8] = '{1'b1, 1'b1, 32'd96,  word_t'(16'h1234), 1'b1};
    tbl[9] = '{1'b0, 1'b1, 32'd96,  '0,          1'b1};
    exp_acc = '{0, 1, 3};
    exp_val = '{3, 4, 6};

    m.avs_read = 1'b0;
    m.avs_write = 1'b0;
    m.avs_address = '0;
    m.avs_writedata = '0;
    m0.avs_read = 1'b0;
    m0.avs_write = 1'b0;
    m0.avs_address = '0;
    m0.avs_writedata = '0;
    load_en = 1'b0;
    load_index = '0;
    load_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wr_m = '0;
    rd_m = '0;
    err_m = 1'b0;

    @(negedge clk);
    chk("rst_waitrequest", word_t'(m.avs_waitrequest), 1);
    chk("rst_rdv", word_t'(m.avs_readdatavalid), 0);
    chk("rst_readdata", m.avs_readdata, '0);
    chk("rst_err", word_t'(err_flag), 0);
    chk("rst_wr_count", word_t'(wr_count), 0);
    chk("rst_rd_count", word_t'(rd_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1;
      load_index = 4'(i);
      load_data = {8{32'hC0DE0000 + 32'(i)}};
      ref_mem[i] = load_data;
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;

    nacc = 0;
    m0.avs_read = 1'b1;
    m0.avs_address = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0.avs_readdatavalid) begin
        val_c.push_back(c);
        val_d.push_back(m0.avs_readdata);
      end
      if (m0.avs_read && !m0.avs_waitrequest) begin
        acc_c.push_back(c);
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc == 3) m0.avs_read = 1'b0;
      else m0.avs_address = 32'(nacc * 32);
    end
    chk("p0_acc_n", word_t'(acc_c.size()), 3);
    chk("p0_val_n", word_t'(val_c.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk("p0_acc_cyc", word_t'(i < acc_c.size() ? acc_c[i] : -1),
          word_t'(exp_acc[i]));
      chk("p0_val_cyc", word_t'(i < val_c.size() ? val_c[i] : -1),
          word_t'(exp_val[i]));
      chk("p0_val_data", i < val_d.size() ? val_d[i] : '0,
          {8{32'hC0DE0000 + 32'(i)}});
    end
    chk("p0_rd_count", word_t'(rd0), 3);

    for (int i = 0; i < 16; i++) begin
      cmd(1'b0, 1'b1, 32'(i * 32), '0, waited);
    end
    drain();
    chk("seq_err", word_t'(err_flag), 0);

    for (int i = 0; i < 10; i++) begin
      cmd(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, waited);
      chk("tbl_wait", word_t'(waited), 1);
      drain();
      chk("tbl_err", word_t'(err_flag), word_t'(tbl[i].err));
    end
    chk("tbl_wr_count", word_t'(wr_count), word_t'(wr_m));
    chk("tbl_rd_count", word_t'(rd_count), word_t'(rd_m));

    m.avs_read = 1'b1;
    m.avs_address = 32'd64;
    @(posedge clk);
    #1;
    m.avs_read = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drop_rd_count", word_t'(rd_count), word_t'(rd_m));
    cmd(1'b0, 1'b1, 32'd64, '0, waited);
    chk("drop_wait", word_t'(waited), 1);
    drain();

    load_en = 1'b1;
    load_index = 4'd2;
    load_data = {8{32'hDEADBEEF}};
    cmd(1'b1, 1'b0, 32'd64, {8{32'h600D600D}}, waited);
    load_en = 1'b0;
    cmd(1'b0, 1'b1, 32'd64, '0, waited);
    drain();

    cmd(1'b0, 1'b1, 32'd96, '0, waited);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_waitrequest", word_t'(m.avs_waitrequest), 1);
    chk("mid_rdv", word_t'(m.avs_readdatavalid), 0);
    chk("mid_readdata", m.avs_readdata, '0);
    chk("mid_err", word_t'(err_flag), 0);
    chk("mid_wr_count", word_t'(wr_count), 0);
    chk("mid_rd_count", word_t'(rd_count), 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wr_m = '0;
    rd_m = '0;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmd(1'b0, 1'b1, 32'd64, '0, waited);
    cmd(1'b0, 1'b1, 32'd96, '0, waited);
    drain();
    chk("post_rd_count", word_t'(rd_count), 2);
    chk("post_err", word_t'(err_flag), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_dram_responder.md
# avalon_dram_responder

Avalon-MM slave (responder) modelling the 256-bit DRAM window that the RSA accelerator's Avalon-MM master reads operands from and writes results to. It accepts single-beat reads and writes with a configurable wait-state stall and a fixed pipelined read latency, and stores data in an internal register array. A backdoor load port lets the host or testbench preload operands. The block sits opposite the accelerator master in simulation and on-chip test builds.

## Interface
- DATA_W, 256, data width in bits (fixed 256; byte lanes unused)
- DEPTH, 16, number of 256-bit words; power of two, 2..64
- READ_LATENCY, 3, cycles from read accept to readdatavalid; 1..8
- WAIT_CYCLES, 1, stall cycles before a held command is accepted; 0..7
- MAX_PENDING, 2, maximum reads in flight; 1..READ_LATENCY
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- avs_address  in  32  byte address; word index = address[5 +: log2(DEPTH)]
- avs_read  in  1  read command
- avs_write  in  1  write command
- avs_writedata  in  256  write data
- avs_waitrequest  out  1  high = command not accepted this cycle
- avs_readdatavalid  out  1  one-cycle pulse, readdata valid
- avs_readdata  out  256  read data
- load_en  in  1  backdoor write strobe
- load_index  in  log2(DEPTH)  backdoor word index
- load_data  in  256  backdoor data
- err_flag  out  1  sticky: misaligned, out-of-range or read+write together
- wr_count  out  16  accepted writes, wraps
- rd_count  out  16  accepted reads, wraps

## Operation
- Request req = avs_read | avs_write. Stall counter wait_cnt (3 bits): 0 when req low; increments each cycle req is held and not accepted, saturating at WAIT_CYCLES.
- Accept (combinational) = req && wait_cnt == WAIT_CYCLES && (avs_write || pending < MAX_PENDING). avs_waitrequest = !accept; therefore high while idle. On accept wait_cnt returns to 0 next cycle.
- Write accept: mem[index] <= avs_writedata, wr_count += 1.
- Read accept: mem[index] sampled in the accept cycle into the read pipeline (READ_LATENCY stages of valid+data); rd_count += 1; pending += 1.
- Pipeline output stage drives avs_readdatavalid; avs_readdata updates only when valid, else holds last value. pending -= 1 on readdatavalid; simultaneous accept and return leaves pending unchanged.
- Address error: address[4:0] != 0 or address >= DEPTH*32. Erroneous write accepted normally but dropped (no memory change, wr_count still increments); erroneous read accepted and returns all zeros. Either sets err_flag.
- read and write asserted together: treated as a write; read ignored; err_flag set.
- Backdoor: load_en writes mem[load_index] in one cycle; if an Avalon write to the same index is accepted in the same cycle, the Avalon write wins. Backdoor does not touch counters or wait_cnt.
- err_flag cleared only by reset.

## Timing
- Reset values: avs_waitrequest 1, avs_readdatavalid 0, avs_readdata 0, err_flag 0, wr_count 0, rd_count 0, pending 0, wait_cnt 0, all memory words 0, pipeline valids 0.
- Command held from cycle T with no back-pressure from pending: accept in cycle T+WAIT_CYCLES; waitrequest low only in that cycle.
- Read accepted in cycle A: readdatavalid high in cycle A+READ_LATENCY, exactly one cycle, data = memory contents at A (a write accepted in A+1 does not affect it).
- WAIT_CYCLES=0: back-to-back accepts every cycle, subject to MAX_PENDING.
- Master dropping req before accept: wait_cnt clears; no side effects.
- Reset mid-operation: in-flight reads discarded, no readdatavalid after reset deassertion until a new read is accepted.

## Test plan
- WAIT_CYCLES=1, READ_LATENCY=3: write 0xA5..A5 to address 64, held from cycle 0 -> waitrequest 1 at cycle 0, 0 at cycle 1; read address 64 accepted at cycle A -> readdatavalid at A+3 with 0xA5..A5, wr_count=1, rd_count=1.
- WAIT_CYCLES=0, MAX_PENDING=2, READ_LATENCY=3: reads to addresses 0, 32, 64 held continuously -> accepts at cycles 0, 1, stall at 2, third accepted at cycle 3 when first data returns; three valid pulses in order at cycles 3, 4, 6.
- Backdoor preload words 0..15 with index-pattern data, then sequential reads of addresses 0..480 step 32 -> readdata matches preloaded patterns, err_flag 0.
- Read address 512 (DEPTH=16) and write address 33 -> read returns 0, write does not modify word 1, err_flag 1 and sticky.
- read+write together to address 96 with data 0x1234 -> written, no readdatavalid, err_flag 1; later read returns 0x1234.
- Reset asserted one cycle after a read accept -> all outputs at reset values, no readdatavalid pulse after release, memory reads back 0.
